// File: rtl/csi_packet_framer.sv
// CSI-2 packet framing controller: turns frame/line pulses into short/long packet
// requests and delay-aligns the byte stream to them, checking line payload length.
module csi_packet_framer #(
    parameter int DATA_DELAY    = 3,
    parameter int FRAME_NUM_MAX = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  vc_i,
    input  logic [1:0]  pix_format_i,
    input  logic [15:0] h_pix_i,
    input  logic        fv_start_i,
    input  logic        fv_end_i,
    input  logic        lv_start_i,
    input  logic        lv_end_i,
    input  logic        byte_en_i,
    input  logic [7:0]  byte_data_i,
    output logic        sp_en_o,
    output logic        lp_en_o,
    output logic [5:0]  dt_o,
    output logic [15:0] wc_o,
    output logic [1:0]  vc_o,
    output logic        byte_en_o,
    output logic [7:0]  byte_data_o,
    output logic        len_err_o,
    output logic        collision_o,
    output logic [15:0] frame_num_o
);

    localparam logic [15:0] FN_MAX    = 16'(FRAME_NUM_MAX);
    localparam bit          NUMBERING = (FRAME_NUM_MAX > 0);

    typedef enum logic [1:0] {IDLE, FRAME, LINE} state_t;

    state_t      state, state_nxt;
    logic        acc_fs, acc_fe, acc_ls, acc_le;
    logic [2:0]  ev_cnt;
    logic [15:0] byte_cnt, byte_cnt_inc, cnt_at_end;
    logic [15:0] frame_num, frame_num_adv;
    logic [15:0] wc_line;
    logic [5:0]  dt_line;
    logic [1:0]  vc_lat;
    logic [8:0]  dly_p [DATA_DELAY];

    function automatic logic [15:0] line_wc(input logic [15:0] h, input logic [1:0] fmt);
        case (fmt)
            2'd0:    return h;
            2'd2:    return h + (h >> 1);
            default: return h + (h >> 2);
        endcase
    endfunction

    function automatic logic [5:0] line_dt(input logic [1:0] fmt);
        case (fmt)
            2'd0:    return 6'h2A;
            2'd2:    return 6'h2C;
            default: return 6'h2B;
        endcase
    endfunction

    // Priority chain works on valid events only, so an ignored pulse never masks a lower one
    always_comb begin
        state_nxt = state;
        acc_fs    = 1'b0;
        acc_fe    = 1'b0;
        acc_ls    = 1'b0;
        acc_le    = 1'b0;
        if (fv_start_i) begin
            acc_fs    = 1'b1;
            state_nxt = FRAME;
        end else if (fv_end_i && state != IDLE) begin
            acc_fe    = 1'b1;
            state_nxt = IDLE;
        end else if (lv_start_i && state == FRAME) begin
            acc_ls    = 1'b1;
            state_nxt = LINE;
        end else if (lv_end_i && state == LINE) begin
            acc_le    = 1'b1;
            state_nxt = FRAME;
        end
    end

    assign ev_cnt        = {2'b00, fv_start_i} + {2'b00, fv_end_i}
                         + {2'b00, lv_start_i} + {2'b00, lv_end_i};
    assign byte_cnt_inc  = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
    assign cnt_at_end    = byte_en_i ? byte_cnt_inc : byte_cnt;
    assign frame_num_adv = (frame_num == 16'd0 || frame_num == FN_MAX) ? 16'd1
                                                                       : frame_num + 16'd1;
    assign frame_num_o   = frame_num;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sp_en_o     <= 1'b0;
            lp_en_o     <= 1'b0;
            dt_o        <= '0;
            wc_o        <= '0;
            vc_o        <= '0;
            len_err_o   <= 1'b0;
            collision_o <= 1'b0;
            byte_cnt    <= '0;
            frame_num   <= '0;
            wc_line     <= '0;
            dt_line     <= '0;
            vc_lat      <= '0;
        end else begin
            sp_en_o     <= acc_fs | acc_fe;
            lp_en_o     <= acc_ls;
            collision_o <= (ev_cnt > 3'd1);
            len_err_o   <= ((acc_fs || acc_fe) && state == LINE)
                         || (acc_le && cnt_at_end != wc_line);

            if (acc_ls) begin
                byte_cnt <= '0;
            end else if (state == LINE && byte_en_i) begin
                byte_cnt <= byte_cnt_inc;
            end

            // Header fields hold between emitted packets
            if (acc_fs) begin
                vc_lat    <= vc_i;
                wc_line   <= line_wc(h_pix_i, pix_format_i);
                dt_line   <= line_dt(pix_format_i);
                frame_num <= frame_num_adv;
                dt_o      <= 6'h00;
                wc_o      <= NUMBERING ? frame_num_adv : 16'd0;
                vc_o      <= vc_i;
            end else if (acc_fe) begin
                dt_o      <= 6'h01;
                wc_o      <= NUMBERING ? frame_num : 16'd0;
                vc_o      <= vc_lat;
            end else if (acc_ls) begin
                dt_o      <= dt_line;
                wc_o      <= wc_line;
                vc_o      <= vc_lat;
            end
        end
    end

    // Byte pipeline: stage 0 samples the input, last stage drives the outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DATA_DELAY; i++) dly_p[i] <= '0;
        end else begin
            dly_p[0] <= {byte_en_i, byte_data_i};
            for (int i = 1; i < DATA_DELAY; i++) dly_p[i] <= dly_p[i-1];
        end
    end

    assign {byte_en_o, byte_data_o} = dly_p[DATA_DELAY-1];

endmodule

// File: tb/tb_csi_packet_framer.sv
// Bench for csi_packet_framer: directed table, multi-cycle corner sequences and
// random traffic, all checked against a frame-level reference model.
module tb_csi_packet_framer;

    localparam int D0   = 3;
    localparam int D1   = 5;
    localparam int MAXB = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  vc_i = '0, fmt = '0;
    logic [15:0] h = '0;
    logic        fs = 0, fe = 0, ls = 0, le = 0, be = 0;
    logic [7:0]  bd = '0;

    logic        a_sp, a_lp, a_beo, a_lerr, a_coll;
    logic [5:0]  a_dt;
    logic [15:0] a_wc, a_fn;
    logic [1:0]  a_vc;
    logic [7:0]  a_bdo;
    logic        b_sp, b_lp, b_beo, b_lerr, b_coll;
    logic [5:0]  b_dt;
    logic [15:0] b_wc, b_fn;
    logic [1:0]  b_vc;
    logic [7:0]  b_bdo;

    always #5 clk = ~clk;

    csi_packet_framer #(.DATA_DELAY(D0), .FRAME_NUM_MAX(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .vc_i(vc_i), .pix_format_i(fmt), .h_pix_i(h),
        .fv_start_i(fs), .fv_end_i(fe), .lv_start_i(ls), .lv_end_i(le),
        .byte_en_i(be), .byte_data_i(bd),
        .sp_en_o(a_sp), .lp_en_o(a_lp), .dt_o(a_dt), .wc_o(a_wc), .vc_o(a_vc),
        .byte_en_o(a_beo), .byte_data_o(a_bdo), .len_err_o(a_lerr),
        .collision_o(a_coll), .frame_num_o(a_fn));

    csi_packet_framer #(.DATA_DELAY(D1), .FRAME_NUM_MAX(MAXB)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .vc_i(vc_i), .pix_format_i(fmt), .h_pix_i(h),
        .fv_start_i(fs), .fv_end_i(fe), .lv_start_i(ls), .lv_end_i(le),
        .byte_en_i(be), .byte_data_i(bd),
        .sp_en_o(b_sp), .lp_en_o(b_lp), .dt_o(b_dt), .wc_o(b_wc), .vc_o(b_vc),
        .byte_en_o(b_beo), .byte_data_o(b_bdo), .len_err_o(b_lerr),
        .collision_o(b_coll), .frame_num_o(b_fn));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: frame/line membership flags plus a byte history
    bit          m_frame, m_line;
    logic [1:0]  m_vc, m_fmt;
    int          m_h, m_cnt, m_fn0, m_fn3;
    logic        e_sp, e_lp, e_lerr, e_coll;
    logic [5:0]  e_dt;
    logic [15:0] e_wc0, e_wc3;
    logic [1:0]  e_vc;
    logic [8:0]  hist[$];

    function automatic int wc_of(input int hv, input logic [1:0] f);
        if (f == 2'd0) return hv;
        if (f == 2'd2) return (hv + hv / 2) % 65536;
        return (hv + hv / 4) % 65536;
    endfunction

    function automatic logic [5:0] dt_of(input logic [1:0] f);
        if (f == 2'd0) return 6'h2A;
        if (f == 2'd2) return 6'h2C;
        return 6'h2B;
    endfunction

    function automatic int fn_adv(input int c, input int mx);
        if (c == 0 || c == mx) return 1;
        return (c + 1) % 65536;
    endfunction

    task automatic model_reset();
        m_frame = 0; m_line = 0; m_vc = 0; m_fmt = 0; m_h = 0; m_cnt = 0;
        m_fn0 = 0; m_fn3 = 0;
        e_sp = 0; e_lp = 0; e_lerr = 0; e_coll = 0; e_dt = 0; e_wc0 = 0; e_wc3 = 0; e_vc = 0;
        hist.delete();
    endtask

    task automatic model_step();
        int c;
        e_sp = 0; e_lp = 0; e_lerr = 0;
        e_coll = (int'(fs) + int'(fe) + int'(ls) + int'(le)) > 1;
        if (fs) begin
            e_lerr = m_line;
            m_fn0 = fn_adv(m_fn0, 0);
            m_fn3 = fn_adv(m_fn3, MAXB);
            e_sp = 1; e_dt = 6'h00; e_wc0 = 0; e_wc3 = 16'(m_fn3); e_vc = vc_i;
            m_vc = vc_i; m_fmt = fmt; m_h = int'(h);
            m_frame = 1; m_line = 0;
        end else if (fe && m_frame) begin
            e_lerr = m_line;
            e_sp = 1; e_dt = 6'h01; e_wc0 = 0; e_wc3 = 16'(m_fn3); e_vc = m_vc;
            m_frame = 0; m_line = 0;
        end else if (ls && m_frame && !m_line) begin
            e_lp = 1; e_dt = dt_of(m_fmt); e_wc0 = 16'(wc_of(m_h, m_fmt)); e_wc3 = e_wc0;
            e_vc = m_vc; m_line = 1; m_cnt = 0;
        end else if (le && m_line) begin
            c = m_cnt + int'(be);
            if (c > 65535) c = 65535;
            e_lerr = (c != wc_of(m_h, m_fmt));
            m_line = 0;
        end else if (m_line && be) begin
            m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        end
        hist.push_back({be, bd});
        if (hist.size() > 8) void'(hist.pop_front());
    endtask

    function automatic logic [8:0] delayed(input int d);
        if (hist.size() >= d) return hist[hist.size() - d];
        return 9'd0;
    endfunction

    task automatic check_model();
        logic [8:0] x0, x1;
        x0 = delayed(D0);
        x1 = delayed(D1);
        chk("m.sp",    32'(a_sp),   32'(e_sp));
        chk("m.lp",    32'(a_lp),   32'(e_lp));
        chk("m.dt",    32'(a_dt),   32'(e_dt));
        chk("m.wc",    32'(a_wc),   32'(e_wc0));
        chk("m.vc",    32'(a_vc),   32'(e_vc));
        chk("m.lerr",  32'(a_lerr), 32'(e_lerr));
        chk("m.coll",  32'(a_coll), 32'(e_coll));
        chk("m.fn",    32'(a_fn),   32'(m_fn0));
        chk("m.byte",  32'({a_beo, a_bdo}), 32'(x0));
        chk("m3.sp",   32'(b_sp),   32'(e_sp));
        chk("m3.lp",   32'(b_lp),   32'(e_lp));
        chk("m3.wc",   32'(b_wc),   32'(e_wc3));
        chk("m3.lerr", 32'(b_lerr), 32'(e_lerr));
        chk("m3.fn",   32'(b_fn),   32'(m_fn3));
        chk("m3.byte", 32'({b_beo, b_bdo}), 32'(x1));
    endtask

    // One clock: inputs are already driven at a negedge; outputs sampled at the next negedge
    task automatic cyc();
        if (reset_n) model_step(); else model_reset();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic ev(input logic s, input logic e, input logic a, input logic b);
        fs = s; fe = e; ls = a; le = b;
    endtask

    typedef struct {
        logic fs, fe, ls, le;
        logic [1:0] vc, fmt;
        logic [15:0] h;
        logic x_sp, x_lp;
        logic [5:0] x_dt;
        logic [15:0] x_wc;
        logic [1:0] x_vc;
        logic x_lerr, x_coll;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic [7:0] bytes [320];
        int exp_fn [5];

        tbl[0]  = '{0,0,1,0, 2'd0,2'd0,16'd0,   0,0,6'h00,16'd0,  2'd0,0,0};
        tbl[1]  = '{1,0,0,0, 2'd2,2'd0,16'd100, 1,0,6'h00,16'd0,  2'd2,0,0};
        tbl[2]  = '{0,0,1,0, 2'd1,2'd0,16'd0,   0,1,6'h2A,16'd100,2'd2,0,0};
        tbl[3]  = '{0,0,0,1, 2'd1,2'd0,16'd0,   0,0,6'h2A,16'd100,2'd2,1,0};
        tbl[4]  = '{1,0,1,0, 2'd1,2'd2,16'd100, 1,0,6'h00,16'd0,  2'd1,0,1};
        tbl[5]  = '{0,0,1,0, 2'd3,2'd0,16'd0,   0,1,6'h2C,16'd150,2'd1,0,0};
        tbl[6]  = '{0,1,0,0, 2'd0,2'd0,16'd0,   1,0,6'h01,16'd0,  2'd1,1,0};
        tbl[7]  = '{1,0,0,0, 2'd0,2'd3,16'd256, 1,0,6'h00,16'd0,  2'd0,0,0};
        tbl[8]  = '{0,0,1,0, 2'd0,2'd0,16'd0,   0,1,6'h2B,16'd320,2'd0,0,0};
        tbl[9]  = '{0,1,0,1, 2'd0,2'd0,16'd0,   1,0,6'h01,16'd0,  2'd0,1,1};
        tbl[10] = '{0,1,0,0, 2'd2,2'd0,16'd0,   0,0,6'h01,16'd0,  2'd0,0,0};
        tbl[11] = '{0,0,0,1, 2'd0,2'd0,16'd0,   0,0,6'h01,16'd0,  2'd0,0,0};
        tbl[12] = '{0,0,1,0, 2'd0,2'd0,16'd0,   0,0,6'h01,16'd0,  2'd0,0,0};
        exp_fn = '{1, 2, 3, 1, 2};

        // Reset state
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst.sp", 32'(a_sp), 0);   chk("rst.lp", 32'(a_lp), 0);
        chk("rst.dt", 32'(a_dt), 0);   chk("rst.wc", 32'(a_wc), 0);
        chk("rst.vc", 32'(a_vc), 0);   chk("rst.lerr", 32'(a_lerr), 0);
        chk("rst.coll", 32'(a_coll), 0); chk("rst.fn", 32'(a_fn), 0);
        chk("rst.byte", 32'({a_beo, a_bdo}), 0);
        reset_n = 1'b1;
        cyc();

        // Directed event table, rows back to back
        for (int i = 0; i < 13; i++) begin
            ev(tbl[i].fs, tbl[i].fe, tbl[i].ls, tbl[i].le);
            vc_i = tbl[i].vc; fmt = tbl[i].fmt; h = tbl[i].h;
            cyc();
            chk($sformatf("tbl%0d.sp", i),   32'(a_sp),   32'(tbl[i].x_sp));
            chk($sformatf("tbl%0d.lp", i),   32'(a_lp),   32'(tbl[i].x_lp));
            chk($sformatf("tbl%0d.dt", i),   32'(a_dt),   32'(tbl[i].x_dt));
            chk($sformatf("tbl%0d.wc", i),   32'(a_wc),   32'(tbl[i].x_wc));
            chk($sformatf("tbl%0d.vc", i),   32'(a_vc),   32'(tbl[i].x_vc));
            chk($sformatf("tbl%0d.lerr", i), 32'(a_lerr), 32'(tbl[i].x_lerr));
            chk($sformatf("tbl%0d.coll", i), 32'(a_coll), 32'(tbl[i].x_coll));
        end
        ev(0, 0, 0, 0);
        cyc();

        // RAW10 frame, 8 lines of 320 bytes
        vc_i = 0; fmt = 1; h = 256;
        ev(1, 0, 0, 0); cyc();
        chk("t1.fs.sp", 32'(a_sp), 1); chk("t1.fs.dt", 32'(a_dt), 0); chk("t1.fs.wc", 32'(a_wc), 0);
        ev(0, 0, 0, 0); cyc();
        for (int l = 0; l < 8; l++) begin
            ev(0, 0, 1, 0); cyc();
            chk("t1.ls.lp", 32'(a_lp), 1); chk("t1.ls.dt", 32'(a_dt), 32'h2B);
            chk("t1.ls.wc", 32'(a_wc), 320);
            ev(0, 0, 0, 0);
            for (int b = 0; b < 320; b++) begin
                be = 1; bd = 8'($urandom); bytes[b] = bd;
                cyc();
                if (b >= D0 - 1) chk("t1.delay", 32'(a_bdo), 32'(bytes[b - (D0 - 1)]));
            end
            be = 0; ev(0, 0, 0, 1); cyc();
            chk("t1.le.lerr", 32'(a_lerr), 0);
            ev(0, 0, 0, 0); cyc();
        end
        ev(0, 1, 0, 0); cyc();
        chk("t1.fe.sp", 32'(a_sp), 1); chk("t1.fe.dt", 32'(a_dt), 1);
        ev(0, 0, 0, 0); repeat (4) cyc();

        // Short line: 319 bytes against wc 320
        ev(1, 0, 0, 0); cyc(); ev(0, 0, 1, 0); cyc(); ev(0, 0, 0, 0);
        be = 1; repeat (319) begin bd = 8'($urandom); cyc(); end
        be = 0; ev(0, 0, 0, 1); cyc();
        chk("t4.short.lerr", 32'(a_lerr), 1);
        ev(0, 1, 0, 0); cyc(); ev(0, 0, 0, 0); cyc();

        // Saturating byte counter: RAW8, wc 65535, 65540 bytes
        fmt = 0; h = 16'hFFFF;
        ev(1, 0, 0, 0); cyc(); ev(0, 0, 1, 0); cyc();
        chk("t4.sat.wc", 32'(a_wc), 32'hFFFF);
        ev(0, 0, 0, 0);
        be = 1; repeat (65540) begin bd = 8'($urandom); cyc(); end
        be = 0; ev(0, 0, 0, 1); cyc();
        chk("t4.sat.lerr", 32'(a_lerr), 0);
        ev(0, 1, 0, 0); cyc(); ev(0, 0, 0, 0); cyc();

        // Reset in the middle of a line
        fmt = 1; h = 256;
        ev(1, 0, 0, 0); cyc(); ev(0, 0, 1, 0); cyc(); ev(0, 0, 0, 0);
        be = 1; repeat (99) begin bd = 8'($urandom); cyc(); end
        bd = 8'hA5; reset_n = 1'b0;
        #1;
        chk("t6.sp", 32'(a_sp), 0); chk("t6.lp", 32'(a_lp), 0); chk("t6.dt", 32'(a_dt), 0);
        chk("t6.wc", 32'(a_wc), 0); chk("t6.lerr", 32'(a_lerr), 0);
        chk("t6.byte", 32'({a_beo, a_bdo}), 0); chk("t6.fn", 32'(a_fn), 0);
        chk("t6.fn3", 32'(b_fn), 0);
        @(negedge clk);
        be = 0;
        cyc(); cyc();
        reset_n = 1'b1;
        repeat (3) begin cyc(); chk("t6.nolerr", 32'(a_lerr), 0); end
        ev(0, 0, 1, 0); cyc();
        chk("t6.idle.lp", 32'(a_lp), 0);
        ev(0, 0, 0, 1); cyc();
        chk("t6.idle.lerr", 32'(a_lerr), 0);

        // Frame numbering, wrap at 3 on the second instance
        fmt = 1; h = 8;
        for (int f = 0; f < 5; f++) begin
            ev(1, 0, 0, 0); cyc();
            chk($sformatf("t3.fs%0d.wc", f), 32'(b_wc), 32'(exp_fn[f]));
            chk($sformatf("t3.fs%0d.fn", f), 32'(b_fn), 32'(exp_fn[f]));
            chk($sformatf("t3.fs%0d.fn0", f), 32'(a_fn), 32'(f + 1));
            chk($sformatf("t3.fs%0d.wc0", f), 32'(a_wc), 0);
            ev(0, 0, 0, 0); cyc();
            ev(0, 1, 0, 0); cyc();
            chk($sformatf("t3.fe%0d.wc", f), 32'(b_wc), 32'(exp_fn[f]));
            chk($sformatf("t3.fe%0d.dt", f), 32'(b_dt), 1);
            ev(0, 0, 0, 0); cyc();
        end

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            ev(logic'($urandom_range(0, 24) == 0), logic'($urandom_range(0, 24) == 0),
               logic'($urandom_range(0, 9) == 0),  logic'($urandom_range(0, 9) == 0));
            be = logic'($urandom_range(0, 3) != 0);
            bd = 8'($urandom);
            vc_i = 2'($urandom);
            fmt = 2'($urandom);
            h = 16'($urandom_range(0, 24));
            cyc();
        end
        ev(0, 0, 0, 0); be = 0;
        repeat (6) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
